// File: rtl/prog_inst_mem_pkg.sv
// prog_inst_mem_pkg
//   Items shared by the instruction memory slice:
//   - INSTR_LEN_DEF : default instruction word width in bits
//   - NOP_WORD_DEF  : fill word after reset and return word for faulting fetches
//   - state_e       : loader/controller FSM states
package prog_inst_mem_pkg;

  localparam int INSTR_LEN_DEF = 32;
  localparam logic [INSTR_LEN_DEF-1:0] NOP_WORD_DEF = 32'hE000_0000;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    LOAD  = 2'd2
  } state_e;

endpackage

// File: rtl/prog_inst_mem_if.sv
// prog_inst_mem_if
//   Bundles the fetch port and the byte loader port of prog_inst_mem.
//   master : drives fetch_req/addr/stall and load_start/base/valid/byte/last
//   slave  : drives fetch_ready/valid/data/misaligned/fault and
//            load_ready/busy/done/overflow/count
interface prog_inst_mem_if
  import prog_inst_mem_pkg::*;
#(
  parameter int INSTRUCTION_LEN = INSTR_LEN_DEF,
  parameter int DEPTH           = 64,
  parameter int ADDR_W          = 32
);
  localparam int AW = $clog2(DEPTH);

  // fetch port
  logic                       fetch_req;
  logic [ADDR_W-1:0]          fetch_addr;
  logic                       fetch_stall;
  logic                       fetch_ready;
  logic                       fetch_valid;
  logic [INSTRUCTION_LEN-1:0] fetch_data;
  logic                       fetch_misaligned;
  logic                       fetch_fault;

  // loader port
  logic                       load_start;
  logic [AW-1:0]              load_base;
  logic                       load_valid;
  logic [7:0]                 load_byte;
  logic                       load_last;
  logic                       load_ready;
  logic                       load_busy;
  logic                       load_done;
  logic                       load_overflow;
  logic [AW:0]                load_count;

  modport master (
    output fetch_req, fetch_addr, fetch_stall,
    output load_start, load_base, load_valid, load_byte, load_last,
    input  fetch_ready, fetch_valid, fetch_data, fetch_misaligned, fetch_fault,
    input  load_ready, load_busy, load_done, load_overflow, load_count
  );

  modport slave (
    input  fetch_req, fetch_addr, fetch_stall,
    input  load_start, load_base, load_valid, load_byte, load_last,
    output fetch_ready, fetch_valid, fetch_data, fetch_misaligned, fetch_fault,
    output load_ready, load_busy, load_done, load_overflow, load_count
  );

endinterface

// File: rtl/prog_inst_mem_ram.sv
// prog_inst_mem_ram
//   Single-port DEPTH x WIDTH storage: synchronous write, read data follows
//   addr combinationally (the caller registers it).
//   clk   : write clock
//   we    : write enable
//   addr  : word index shared by read and write
//   wdata : write word
//   rdata : word at addr
module prog_inst_mem_ram
  import prog_inst_mem_pkg::*;
#(
  parameter int WIDTH = INSTR_LEN_DEF,
  parameter int DEPTH = 64
)(
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // word write
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/prog_inst_mem.sv
// prog_inst_mem
//   Byte-loadable instruction memory. After reset it writes NOP_WORD to every
//   word (CLEAR), then serves fetches (IDLE) or assembles a big-endian byte
//   stream into words (LOAD).
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of prog_inst_mem_if (fetch port + loader port)
module prog_inst_mem
  import prog_inst_mem_pkg::*;
#(
  parameter int INSTRUCTION_LEN = INSTR_LEN_DEF,
  parameter int DEPTH           = 64,
  parameter int ADDR_W          = 32,
  parameter logic [INSTRUCTION_LEN-1:0] NOP_WORD = NOP_WORD_DEF
)(
  input  logic           clk,
  input  logic           rst,
  prog_inst_mem_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int BYTES = INSTRUCTION_LEN / 8;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [AW:0]       DEPTH_P   = (AW+1)'(DEPTH);
  localparam logic [ADDR_W-3:0] DEPTH_W   = (ADDR_W-2)'(DEPTH);
  localparam logic [AW-1:0]     LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [CW-1:0]     LAST_BYTE = CW'(BYTES - 1);

  state_e                     state_r, state_s;
  logic [AW-1:0]              clr_idx_r;
  logic [AW:0]                ptr_r;
  logic [CW-1:0]              byte_cnt_r;
  logic [INSTRUCTION_LEN-1:0] asm_r, word_s;
  logic [AW:0]                count_r;
  logic                       overflow_r, done_r;
  logic                       byte_acc_s, commit_s, ptr_ok_s;

  logic [ADDR_W-3:0]          fidx_s;
  logic                       fault_s, fetch_acc_s;
  logic                       fetch_valid_r, mis_r, fault_r;
  logic [INSTRUCTION_LEN-1:0] fetch_data_r;

  logic                       ram_we_s;
  logic [AW-1:0]              ram_addr_s;
  logic [INSTRUCTION_LEN-1:0] ram_wdata_s, ram_rdata_s;

  // The pointer has one extra bit so indices at or past DEPTH are visible.
  assign byte_acc_s  = bus.load_valid && (state_r == LOAD);
  assign commit_s    = byte_acc_s && (bus.load_last || (byte_cnt_r == LAST_BYTE));
  assign ptr_ok_s    = (ptr_r < DEPTH_P);
  assign fidx_s      = bus.fetch_addr[ADDR_W-1:2];
  assign fault_s     = (fidx_s >= DEPTH_W);
  assign fetch_acc_s = bus.fetch_req && (state_r == IDLE) && !bus.fetch_stall;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= CLEAR;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      CLEAR: begin
        if (clr_idx_r == LAST_IDX) state_s = IDLE;
        else                       state_s = CLEAR;
      end
      IDLE: begin
        if (bus.load_start) state_s = LOAD;
        else                state_s = IDLE;
      end
      LOAD: begin
        if (byte_acc_s && bus.load_last) state_s = IDLE;
        else                             state_s = LOAD;
      end
      default: state_s = CLEAR;
    endcase
  end

  // state-dependent handshakes and RAM port steering
  always_comb begin
    bus.fetch_ready = 1'b0;
    bus.load_ready  = 1'b0;
    bus.load_busy   = 1'b1;
    ram_we_s        = 1'b0;
    ram_addr_s      = fidx_s[AW-1:0];
    ram_wdata_s     = NOP_WORD;
    case (state_r)
      CLEAR: begin
        ram_we_s   = 1'b1;
        ram_addr_s = clr_idx_r;
      end
      IDLE: begin
        bus.fetch_ready = !bus.fetch_stall;
        bus.load_busy   = 1'b0;
      end
      LOAD: begin
        bus.load_ready = 1'b1;
        ram_we_s       = commit_s && ptr_ok_s;
        ram_addr_s     = ptr_r[AW-1:0];
        ram_wdata_s    = word_s;
      end
      default: begin
        ram_we_s = 1'b0;
      end
    endcase
  end

  // place the incoming byte MSB-first; not-yet-received bytes stay zero
  always_comb begin
    word_s = asm_r;
    for (int b = 0; b < BYTES; b++) begin
      if (b == (BYTES - 1 - int'(byte_cnt_r))) word_s[b*8 +: 8] = bus.load_byte;
      else                                     word_s[b*8 +: 8] = asm_r[b*8 +: 8];
    end
  end

  // clear sweep index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_idx_r <= '0;
    end else if (state_r == CLEAR && clr_idx_r != LAST_IDX) begin
      clr_idx_r <= clr_idx_r + AW'(1);
    end else begin
      clr_idx_r <= '0;
    end
  end

  // loader session: pointer, byte assembler, counters and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r      <= '0;
      byte_cnt_r <= '0;
      asm_r      <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= byte_acc_s && bus.load_last;
      if (state_r == IDLE && bus.load_start) begin
        ptr_r      <= {1'b0, bus.load_base};
        byte_cnt_r <= '0;
        asm_r      <= '0;
        count_r    <= '0;
        overflow_r <= 1'b0;
      end else if (commit_s) begin
        byte_cnt_r <= '0;
        asm_r      <= '0;
        if (ptr_ok_s) begin
          ptr_r <= ptr_r + (AW+1)'(1);
          if (count_r < DEPTH_P) count_r <= count_r + (AW+1)'(1);
        end else begin
          overflow_r <= 1'b1;
        end
      end else if (byte_acc_s) begin
        byte_cnt_r <= byte_cnt_r + CW'(1);
        asm_r      <= word_s;
      end
    end
  end

  // fetch output register; stall freezes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_valid_r <= 1'b0;
      fetch_data_r  <= '0;
      mis_r         <= 1'b0;
      fault_r       <= 1'b0;
    end else if (bus.fetch_stall) begin
      fetch_valid_r <= fetch_valid_r;
    end else if (fetch_acc_s) begin
      fetch_valid_r <= 1'b1;
      fetch_data_r  <= fault_s ? NOP_WORD : ram_rdata_s;
      mis_r         <= (bus.fetch_addr[1:0] != 2'b00);
      fault_r       <= fault_s;
    end else begin
      fetch_valid_r <= 1'b0;
    end
  end

  assign bus.fetch_valid      = fetch_valid_r;
  assign bus.fetch_data       = fetch_data_r;
  assign bus.fetch_misaligned = mis_r;
  assign bus.fetch_fault      = fault_r;
  assign bus.load_done        = done_r;
  assign bus.load_overflow    = overflow_r;
  assign bus.load_count       = count_r;

  prog_inst_mem_ram #(
    .WIDTH (INSTRUCTION_LEN),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

endmodule

// File: tb/tb_prog_inst_mem.sv
// tb_prog_inst_mem
//   Self-checking bench for prog_inst_mem: fetch expectations are queued when
//   a fetch is driven and compared when the output register updates.
module tb_prog_inst_mem;
  import prog_inst_mem_pkg::*;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;
  localparam int W      = 32;
  localparam int AW     = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'hE000_0000;

  typedef struct {
    logic [31:0] data;
    logic        mis;
    logic        fault;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        mis;
    logic        fault;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  logic acc_q = 1'b0;

  prog_inst_mem_if #(.INSTRUCTION_LEN(W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  prog_inst_mem #(
    .INSTRUCTION_LEN (W),
    .DEPTH           (DEPTH),
    .ADDR_W          (ADDR_W),
    .NOP_WORD        (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // remember whether a fetch was accepted at this edge
  always @(posedge clk) acc_q <= bus.fetch_req && bus.fetch_ready && !rst;

  // scoreboard compare, half a cycle after the accepting edge
  always @(negedge clk) begin
    if (acc_q) begin
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL fetch_unexpected: accept with empty scoreboard, data %h", bus.fetch_data);
      end else begin
        e = sb_q.pop_front();
        if (!(bus.fetch_valid === 1'b1 && bus.fetch_data === e.data &&
              bus.fetch_misaligned === e.mis && bus.fetch_fault === e.fault)) begin
          errors++;
          $display("FAIL fetch_out: got valid=%b data=%h mis=%b fault=%b, expected valid=1 data=%h mis=%b fault=%b",
                   bus.fetch_valid, bus.fetch_data, bus.fetch_misaligned, bus.fetch_fault,
                   e.data, e.mis, e.fault);
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] addr, input logic [31:0] d, input logic m, input logic f);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = addr;
    e.data = d; e.mis = m; e.fault = f;
    sb_q.push_back(e);
    #1;
    n = 0;
    while (!bus.fetch_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!bus.fetch_ready) begin
      checks++; errors++;
      $display("FAIL fetch_timeout: fetch_ready=0 after %0d cycles, required 1", n);
      void'(sb_q.pop_back());
      bus.fetch_req = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      bus.fetch_req = 1'b0;
    end
  endtask

  // bytes come from bv most significant first; last byte carries load_last
  task automatic load(input logic [AW-1:0] base, input logic [63:0] bv, input int n);
    @(negedge clk);
    bus.load_start = 1'b1;
    bus.load_base  = base;
    @(negedge clk);
    bus.load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.load_valid = 1'b1;
      bus.load_byte  = bv[63-8*i -: 8];
      bus.load_last  = (i == n - 1);
      if (i == 0) check("load_ready", 32'(bus.load_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic wait_clear(input string name);
    int cycles;
    cycles = 0;
    do begin
      @(posedge clk); #1; cycles++;
    end while (!bus.fetch_ready && cycles < 4 * DEPTH);
    check(name, cycles, DEPTH);
  endtask

  initial begin
    vec_t vecs[10];

    bus.fetch_req = 1'b0; bus.fetch_addr = '0; bus.fetch_stall = 1'b0;
    bus.load_start = 1'b0; bus.load_base = '0; bus.load_valid = 1'b0;
    bus.load_byte = 8'h00; bus.load_last = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    check("rst_fetch_data", bus.fetch_data, 32'd0);
    check("rst_fetch_flags", {30'd0, bus.fetch_misaligned, bus.fetch_fault}, 32'd0);
    check("rst_load_ready", 32'(bus.load_ready), 32'd0);
    check("rst_load_busy", 32'(bus.load_busy), 32'd1);
    check("rst_load_done_ovf", {30'd0, bus.load_done, bus.load_overflow}, 32'd0);
    check("rst_load_count", 32'(bus.load_count), 32'd0);

    // clear sweep length
    rst = 1'b0;
    wait_clear("clear_cycles");
    check("idle_busy", 32'(bus.load_busy), 32'd0);
    fetch(32'h0, NOP, 1'b0, 1'b0);

    // full-word load
    load(AW'(1), 64'hE3A0_0014_0000_0000, 4);
    check("full_done", 32'(bus.load_done), 32'd1);
    check("full_count", 32'(bus.load_count), 32'd1);
    check("full_ovf", 32'(bus.load_overflow), 32'd0);
    check("full_busy", 32'(bus.load_busy), 32'd0);
    @(negedge clk);
    check("done_pulse_end", 32'(bus.load_done), 32'd0);

    // partial-word load
    load(AW'(2), 64'h1234_0000_0000_0000, 2);
    check("part_done", 32'(bus.load_done), 32'd1);
    check("part_count", 32'(bus.load_count), 32'd1);

    // fetch vectors
    vecs[0] = '{32'h0000_0000, NOP,          1'b0, 1'b0};
    vecs[1] = '{32'h0000_0004, 32'hE3A00014, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_0006, 32'hE3A00014, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0008, 32'h12340000, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_000C, NOP,          1'b0, 1'b0};
    vecs[5] = '{32'(4 * DEPTH), NOP,         1'b0, 1'b1};
    vecs[6] = '{32'hFFFF_FFFC, NOP,          1'b0, 1'b1};
    vecs[7] = '{32'h0000_0007, 32'hE3A00014, 1'b1, 1'b0};
    vecs[8] = '{32'h0000_0103, NOP,          1'b1, 1'b1};
    vecs[9] = '{32'h0000_00FC, NOP,          1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      fetch(vecs[i].addr, vecs[i].data, vecs[i].mis, vecs[i].fault);
    end
    @(negedge clk);
    check("valid_drop", 32'(bus.fetch_valid), 32'd0);

    // stall hold
    fetch(32'h4, 32'hE3A00014, 1'b0, 1'b0);
    begin
      exp_t e;
      bus.fetch_stall = 1'b1;
      bus.fetch_req   = 1'b1;
      bus.fetch_addr  = 32'h8;
      e.data = 32'h12340000; e.mis = 1'b0; e.fault = 1'b0;
      sb_q.push_back(e);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.fetch_valid), 32'd1);
      check("stall_data", bus.fetch_data, 32'hE3A00014);
      check("stall_ready", 32'(bus.fetch_ready), 32'd0);
    end
    bus.fetch_stall = 1'b0;
    #1;
    check("release_ready", 32'(bus.fetch_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.fetch_req = 1'b0;

    // overflow past the last word
    load(AW'(DEPTH - 1), 64'h1122_3344_5566_7788, 8);
    check("ovf_count", 32'(bus.load_count), 32'd1);
    check("ovf_flag", 32'(bus.load_overflow), 32'd1);
    check("ovf_done", 32'(bus.load_done), 32'd1);
    fetch(32'(4 * (DEPTH - 1)), 32'h11223344, 1'b0, 1'b0);
    fetch(32'h0, NOP, 1'b0, 1'b0);

    // reset in the middle of a load
    @(negedge clk);
    bus.load_start = 1'b1;
    bus.load_base  = '0;
    @(negedge clk);
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_byte  = 8'hAA;
    @(negedge clk);
    bus.load_byte  = 8'hBB;
    @(negedge clk);
    bus.load_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ovf", 32'(bus.load_overflow), 32'd0);
    check("midrst_count", 32'(bus.load_count), 32'd0);
    check("midrst_busy", 32'(bus.load_busy), 32'd1);
    check("midrst_load_ready", 32'(bus.load_ready), 32'd0);
    rst = 1'b0;
    wait_clear("reclear_cycles");
    for (int i = 0; i < DEPTH; i++) begin
      fetch(32'(4 * i), NOP, 1'b0, 1'b0);
    end
    check("final_ovf", 32'(bus.load_overflow), 32'd0);

    @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
